// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and feeds IF/ID.
// Absorbs memory wait states, downstream stalls and taken-branch redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_READDATA,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_INCREMENT4,
    output logic        BUSY_WAIT,
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_instr, hold_next;
    logic [31:0] redirect_pc, redirect_next;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        read_int;
    logic        busy_int;
    logic [31:0] instr_int;

    assign pc_plus4 = pc + 32'd4;
    assign target   = BRANCH_TARGET & ~32'h0000_0003;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= BUBBLE;
            redirect_pc <= RESET_PC;
        end else begin
            state       <= next_state;
            pc          <= pc_next;
            hold_instr  <= hold_next;
            redirect_pc <= redirect_next;
        end
    end

    // Handshake: IF/ID latches INSTRUCTION/PC_INCREMENT4 on a rising edge only when BUSY_WAIT=0.
    always_comb begin
        next_state    = state;
        pc_next       = pc;
        hold_next     = hold_instr;
        redirect_next = redirect_pc;
        read_int      = 1'b0;
        busy_int      = 1'b1;
        instr_int     = BUBBLE;
        case (state)
            FETCH: begin
                read_int = 1'b1;
                if (IMEM_BUSYWAIT) begin
                    if (BRANCH_TAKEN) begin
                        redirect_next = target;
                        next_state    = REDIRECT;
                    end
                end else if (BRANCH_TAKEN) begin
                    busy_int = 1'b0;
                    pc_next  = target;
                end else if (STALL) begin
                    instr_int  = IMEM_READDATA;
                    hold_next  = IMEM_READDATA;
                    next_state = HOLD;
                end else begin
                    instr_int = IMEM_READDATA;
                    busy_int  = 1'b0;
                    pc_next   = pc_plus4;
                end
            end
            HOLD: begin
                instr_int = hold_instr;
                if (BRANCH_TAKEN) begin
                    instr_int  = BUBBLE;
                    busy_int   = 1'b0;
                    pc_next    = target;
                    next_state = FETCH;
                end else if (!STALL) begin
                    busy_int   = 1'b0;
                    pc_next    = pc_plus4;
                    next_state = FETCH;
                end
            end
            REDIRECT: begin
                // The wrong-path read at the old PC is allowed to complete, then dropped.
                read_int = 1'b1;
                if (BRANCH_TAKEN) begin
                    redirect_next = target;
                end
                if (!IMEM_BUSYWAIT) begin
                    pc_next    = BRANCH_TAKEN ? target : redirect_pc;
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign IMEM_READ     = RESET_N & read_int;
    assign IMEM_ADDRESS  = pc;
    assign INSTRUCTION   = RESET_N ? instr_int : BUBBLE;
    assign PC_INCREMENT4 = pc_plus4;
    assign BUSY_WAIT     = ~RESET_N | busy_int;
    assign DBG_STATE     = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scoreboard of IF/ID captures
// plus per-scenario checks of PC, read strobe and stall handshake.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_INCREMENT4;
    logic        BUSY_WAIT;
    logic [1:0]  DBG_STATE;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    instruction_fetch_unit dut (
        .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .INSTRUCTION(INSTRUCTION), .PC_INCREMENT4(PC_INCREMENT4), .BUSY_WAIT(BUSY_WAIT),
        .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    always_comb IMEM_READDATA = IMEM_BUSYWAIT ? 32'hDEAD_BEEF : mem_word(IMEM_ADDRESS);

    // scoreboard: every IF/ID capture pops one expected {instruction, pc+4}
    always @(negedge CLK) begin
        if (RESET_N && !BUSY_WAIT) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h/%h exp=none", INSTRUCTION, PC_INCREMENT4);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({INSTRUCTION, PC_INCREMENT4} !== e) begin
                    bad++;
                    $display("FAIL sb_capture got=%h/%h exp=%h/%h",
                             INSTRUCTION, PC_INCREMENT4, e[63:32], e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic busy, input logic stall, input logic br,
                         input logic [31:0] tgt);
        IMEM_BUSYWAIT = busy;
        STALL         = stall;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++; if (IMEM_READ !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", IMEM_READ); end
        total++; if (IMEM_ADDRESS !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", IMEM_ADDRESS); end
        total++; if (INSTRUCTION !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", INSTRUCTION); end
        total++; if (PC_INCREMENT4 !== 32'h4) begin bad++; $display("FAIL rst_pc4 got=%h exp=4", PC_INCREMENT4); end
        total++; if (BUSY_WAIT !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", BUSY_WAIT); end
        total++; if (DBG_STATE !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", DBG_STATE); end
        next_edge();
        RESET_N = 1'b1;
    endtask

    // words 0x0..0xC back-to-back, leaves PC at 0x10
    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            exp_q.push_back({mem_word(a), a + 32'd4});
            @(negedge CLK);
            total++; if (IMEM_ADDRESS !== a || IMEM_READ !== 1'b1) begin
                bad++; $display("FAIL seq_addr got=%h/%b exp=%h/1", IMEM_ADDRESS, IMEM_READ, a);
            end
            next_edge();
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge CLK);
            total++; if (BUSY_WAIT !== 1'b1 || IMEM_ADDRESS !== 32'h10) begin
                bad++; $display("FAIL miss_wait got=%b/%h exp=1/00000010", BUSY_WAIT, IMEM_ADDRESS);
            end
            next_edge();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({mem_word(32'h10), 32'h14});
        next_edge();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h14 + 32'(i * 4);
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            exp_q.push_back({mem_word(a), a + 32'd4});
            next_edge();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge CLK);
        total++; if (INSTRUCTION !== mem_word(32'h20) || BUSY_WAIT !== 1'b1) begin
            bad++; $display("FAIL stall_first got=%h/%b exp=%h/1", INSTRUCTION, BUSY_WAIT, mem_word(32'h20));
        end
        next_edge();
        @(negedge CLK);
        total++; if (IMEM_READ !== 1'b0 || INSTRUCTION !== mem_word(32'h20) || PC_INCREMENT4 !== 32'h24
                     || DBG_STATE !== 2'd1) begin
            bad++; $display("FAIL stall_hold got=%b/%h/%h st=%0d exp=0/%h/00000024 st=1",
                            IMEM_READ, INSTRUCTION, PC_INCREMENT4, DBG_STATE, mem_word(32'h20));
        end
        next_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({mem_word(32'h20), 32'h24});
        @(negedge CLK);
        total++; if (IMEM_READ !== 1'b0 || IMEM_ADDRESS !== 32'h20) begin
            bad++; $display("FAIL stall_release got=%b/%h exp=0/00000020", IMEM_READ, IMEM_ADDRESS);
        end
        next_edge();
        exp_q.push_back({mem_word(32'h24), 32'h28});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'h24) begin
            bad++; $display("FAIL stall_advance got=%h exp=00000024", IMEM_ADDRESS);
        end
        next_edge();
    endtask

    task automatic test_branch_miss();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'h28 + 32'(i * 4);
            exp_q.push_back({mem_word(a), a + 32'd4});
            next_edge();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h103);
        next_edge();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        total++; if (DBG_STATE !== 2'd2 || INSTRUCTION !== 32'h0 || BUSY_WAIT !== 1'b1
                     || IMEM_ADDRESS !== 32'h40 || IMEM_READ !== 1'b1) begin
            bad++; $display("FAIL redir_wait got=st%0d/%h/%b/%h/%b exp=st2/0/1/00000040/1",
                            DBG_STATE, INSTRUCTION, BUSY_WAIT, IMEM_ADDRESS, IMEM_READ);
        end
        next_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        total++; if (BUSY_WAIT !== 1'b1 || INSTRUCTION !== 32'h0) begin
            bad++; $display("FAIL redir_discard got=%b/%h exp=1/0", BUSY_WAIT, INSTRUCTION);
        end
        next_edge();
        exp_q.push_back({mem_word(32'h100), 32'h104});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'h100) begin
            bad++; $display("FAIL redir_target got=%h exp=00000100", IMEM_ADDRESS);
        end
        next_edge();
    endtask

    task automatic test_branch_hold();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        next_edge();
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        exp_q.push_back({32'h0, 32'h108});
        @(negedge CLK);
        total++; if (INSTRUCTION !== 32'h0 || BUSY_WAIT !== 1'b0) begin
            bad++; $display("FAIL hold_branch got=%h/%b exp=0/0", INSTRUCTION, BUSY_WAIT);
        end
        next_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({mem_word(32'h200), 32'h204});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'h200 || DBG_STATE !== 2'd0) begin
            bad++; $display("FAIL hold_target got=%h st=%0d exp=00000200 st=0", IMEM_ADDRESS, DBG_STATE);
        end
        next_edge();
    endtask

    task automatic test_back_to_back(output logic [31:0] pc_out);
        logic [31:0] pc;
        pc = 32'h204;
        for (int i = 0; i < 24; i++) begin
            logic busy;
            busy = ($urandom_range(0, 3) == 0);
            drive(busy, 1'b0, 1'b0, 32'h0);
            if (!busy) exp_q.push_back({mem_word(pc), pc + 32'd4});
            @(negedge CLK);
            total++; if (IMEM_ADDRESS !== pc) begin
                bad++; $display("FAIL b2b_addr got=%h exp=%h", IMEM_ADDRESS, pc);
            end
            next_edge();
            if (!busy) pc = pc + 32'd4;
        end
        pc_out = pc;
    endtask

    task automatic test_wrap(input logic [31:0] pc);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        exp_q.push_back({32'h0, pc + 32'd4});
        next_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'hFFFF_FFFC || PC_INCREMENT4 !== 32'h0) begin
            bad++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", IMEM_ADDRESS, PC_INCREMENT4);
        end
        next_edge();
        exp_q.push_back({mem_word(32'h0), 32'h4});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'h0) begin
            bad++; $display("FAIL wrap_next got=%h exp=0", IMEM_ADDRESS);
        end
        next_edge();
    endtask

    task automatic test_reset_mid(input logic redirect);
        drive(1'b1, 1'b0, redirect, 32'h500);
        next_edge();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        RESET_N = 1'b0;
        #1;
        total++; if (IMEM_READ !== 1'b0 || IMEM_ADDRESS !== 32'h0 || DBG_STATE !== 2'd0 || BUSY_WAIT !== 1'b1) begin
            bad++; $display("FAIL reset_mid got=%b/%h st%0d/%b exp=0/0 st0/1",
                            IMEM_READ, IMEM_ADDRESS, DBG_STATE, BUSY_WAIT);
        end
        next_edge();
        next_edge();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        RESET_N = 1'b1;
        exp_q.push_back({mem_word(32'h0), 32'h4});
        next_edge();
        exp_q.push_back({mem_word(32'h4), 32'h8});
        @(negedge CLK);
        total++; if (IMEM_ADDRESS !== 32'h4) begin
            bad++; $display("FAIL reset_resume got=%h exp=00000004", IMEM_ADDRESS);
        end
        next_edge();
    endtask

    initial begin
        logic [31:0] pc_end;
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_sequential();
        test_miss();
        test_stall();
        test_branch_miss();
        test_branch_hold();
        test_back_to_back(pc_end);
        test_wrap(pc_end);
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        total++; if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
